// File: rtl/sensor_conditioner_pkg.sv
// Shared types and constants for the wheel-speed and range conditioning paths.
package sensor_conditioner_pkg;

  localparam int unsigned DEFAULT_WINDOW_CYCLES  = 1000;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 4000;

  // Moving-average depth and derived widths
  localparam int unsigned AVG_DEPTH  = 4;
  localparam int unsigned AVG_SHIFT  = $clog2(AVG_DEPTH);
  localparam int unsigned DIST_W     = 7;
  localparam int unsigned SPEED_W    = 8;
  localparam int unsigned SUM_W      = DIST_W + AVG_SHIFT;
  localparam int unsigned FILL_CNT_W = $clog2(AVG_DEPTH);

  typedef enum logic [1:0] {
    RANGE_FILL  = 2'd0,
    RANGE_RUN   = 2'd1,
    RANGE_FAULT = 2'd2
  } range_state_e;

  // Entry 0 holds the newest sample
  typedef logic [AVG_DEPTH-1:0][DIST_W-1:0] sample_buf_t;

  // Floor of the mean of all buffered samples, summed at full width
  function automatic logic [DIST_W-1:0] avg_of(input sample_buf_t samples_in);
    logic [SUM_W-1:0] sum;
    sum = '0;
    for (int unsigned i = 0; i < AVG_DEPTH; i++) begin
      sum = sum + SUM_W'(samples_in[i]);
    end
    return DIST_W'(sum >> AVG_SHIFT);
  endfunction

endpackage

// File: rtl/sensor_conditioner_pulse_window_counter.sv
// Wheel tick counter: synchronizer, rising-edge detect, fixed window, saturating count.
module pulse_window_counter
  import sensor_conditioner_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wheel_pulse,
  output logic [SPEED_W-1:0] car_speed,
  output logic               speed_valid
);

  localparam int unsigned WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [SPEED_W-1:0] TICK_MAX = '1;

  logic               sync_q1;
  logic               sync_q2;
  logic               pulse_prev;
  logic               tick_c;
  logic               win_last_c;
  logic [WIN_W-1:0]   win_cnt;
  logic [SPEED_W-1:0] tick_cnt;
  logic [SPEED_W-1:0] tick_cnt_inc_c;

  // Two-flop synchronizer plus the delayed copy used for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      pulse_prev <= 1'b0;
    end else begin
      sync_q1    <= wheel_pulse;
      sync_q2    <= sync_q1;
      pulse_prev <= sync_q2;
    end
  end

  assign tick_c         = sync_q2 & ~pulse_prev;
  assign win_last_c     = (win_cnt == WIN_LAST);
  assign tick_cnt_inc_c = (tick_c && (tick_cnt != TICK_MAX)) ? tick_cnt + SPEED_W'(1) : tick_cnt;

  // Window counter and tick accumulator; the last window cycle publishes the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt     <= '0;
      tick_cnt    <= '0;
      car_speed   <= '0;
      speed_valid <= 1'b0;
    end else begin
      speed_valid <= win_last_c;
      if (win_last_c) begin
        win_cnt   <= '0;
        tick_cnt  <= '0;
        car_speed <= tick_cnt_inc_c;
      end else begin
        win_cnt   <= win_cnt + WIN_W'(1);
        tick_cnt  <= tick_cnt_inc_c;
      end
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions the wheel tick sensor into a speed and the range sensor into a filtered distance.
module sensor_conditioner
  import sensor_conditioner_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES  = DEFAULT_WINDOW_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wheel_pulse,
  input  logic               range_valid,
  input  logic [DIST_W-1:0]  range_data,
  output logic [SPEED_W-1:0] car_speed,
  output logic [DIST_W-1:0]  leading_distance,
  output logic               speed_valid,
  output logic               range_fault
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FILL_CNT_W-1:0] FILL_LAST = FILL_CNT_W'(AVG_DEPTH - 1);

  range_state_e          state;
  range_state_e          state_d;
  sample_buf_t           samples;
  sample_buf_t           samples_d;
  logic [FILL_CNT_W-1:0] fill_cnt;
  logic [FILL_CNT_W-1:0] fill_cnt_d;
  logic [TO_W-1:0]       to_cnt;
  logic [TO_W-1:0]       to_cnt_d;
  logic                  expire_c;
  logic [DIST_W-1:0]     dist_d;
  logic                  fault_d;

  // Speed path runs on its own; nothing here can stall it
  pulse_window_counter #(
    .WINDOW_CYCLES (WINDOW_CYCLES)
  ) u_pulse_window_counter (
    .clk         (clk),
    .rst         (rst),
    .wheel_pulse (wheel_pulse),
    .car_speed   (car_speed),
    .speed_valid (speed_valid)
  );

  // A new sample always beats a coincident timeout
  assign expire_c = !range_valid && (to_cnt == TO_LAST);

  // Range FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RANGE_FILL;
    end else begin
      state <= state_d;
    end
  end

  // Range FSM next-state logic
  always_comb begin
    state_d = state;
    case (state)
      RANGE_FILL: begin
        if (range_valid && (fill_cnt == FILL_LAST)) begin
          state_d = RANGE_RUN;
        end else if (expire_c) begin
          state_d = RANGE_FAULT;
        end
      end
      RANGE_RUN: begin
        if (expire_c) begin
          state_d = RANGE_FAULT;
        end
      end
      RANGE_FAULT: begin
        if (range_valid) begin
          state_d = RANGE_FILL;
        end
      end
      default: state_d = RANGE_FILL;
    endcase
  end

  // Sample buffer, fill count and silence counter updates
  always_comb begin
    samples_d  = samples;
    fill_cnt_d = fill_cnt;
    to_cnt_d   = to_cnt;
    if (state == RANGE_FAULT) begin
      samples_d  = '0;
      fill_cnt_d = '0;
      to_cnt_d   = '0;
      if (range_valid) begin
        samples_d[0] = range_data;
        fill_cnt_d   = FILL_CNT_W'(1);
      end
    end else if (range_valid) begin
      samples_d = {samples[AVG_DEPTH-2:0], range_data};
      to_cnt_d  = '0;
      if (fill_cnt != FILL_LAST) begin
        fill_cnt_d = fill_cnt + FILL_CNT_W'(1);
      end
    end else if (expire_c) begin
      samples_d  = '0;
      fill_cnt_d = '0;
      to_cnt_d   = '0;
    end else begin
      to_cnt_d = to_cnt + TO_W'(1);
    end
  end

  // Output decode from the upcoming state so the average lands one cycle after its sample
  always_comb begin
    dist_d  = '0;
    fault_d = 1'b0;
    case (state_d)
      RANGE_RUN:   dist_d  = avg_of(samples_d);
      RANGE_FAULT: fault_d = 1'b1;
      default: begin
        dist_d  = '0;
        fault_d = 1'b0;
      end
    endcase
  end

  // Range datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samples          <= '0;
      fill_cnt         <= '0;
      to_cnt           <= '0;
      leading_distance <= '0;
      range_fault      <= 1'b0;
    end else begin
      samples          <= samples_d;
      fill_cnt         <= fill_cnt_d;
      to_cnt           <= to_cnt_d;
      leading_distance <= dist_d;
      range_fault      <= fault_d;
    end
  end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: speed windows, saturation, averaging, timeout, reset.
module tb_sensor_conditioner;

  localparam int unsigned WIN     = 20;
  localparam int unsigned TMO     = 50;
  localparam int unsigned WIN_SAT = 700;

  logic       clk;
  logic       rst;
  logic       wheel_pulse;
  logic       wheel_pulse_sat;
  logic       range_valid;
  logic [6:0] range_data;
  logic [7:0] car_speed;
  logic [7:0] car_speed_sat;
  logic [6:0] leading_distance;
  logic [6:0] leading_distance_sat;
  logic       speed_valid;
  logic       speed_valid_sat;
  logic       range_fault;
  logic       range_fault_sat;

  int checks = 0;
  int errors = 0;
  int speed_q[$];
  int dist_q[$];

  sensor_conditioner #(
    .WINDOW_CYCLES  (WIN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .wheel_pulse      (wheel_pulse),
    .range_valid      (range_valid),
    .range_data       (range_data),
    .car_speed        (car_speed),
    .leading_distance (leading_distance),
    .speed_valid      (speed_valid),
    .range_fault      (range_fault)
  );

  sensor_conditioner #(
    .WINDOW_CYCLES  (WIN_SAT),
    .TIMEOUT_CYCLES (TMO)
  ) dut_sat (
    .clk              (clk),
    .rst              (rst),
    .wheel_pulse      (wheel_pulse_sat),
    .range_valid      (range_valid),
    .range_data       (range_data),
    .car_speed        (car_speed_sat),
    .leading_distance (leading_distance_sat),
    .speed_valid      (speed_valid_sat),
    .range_fault      (range_fault_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clean pulse per two cycles, edges launched at the falling clock edge
  task automatic drive_pulses(input int n, input bit sat);
    for (int i = 0; i < n; i++) begin
      if (sat) wheel_pulse_sat = 1'b1; else wheel_pulse = 1'b1;
      @(negedge clk);
      if (sat) wheel_pulse_sat = 1'b0; else wheel_pulse = 1'b0;
      @(negedge clk);
    end
  endtask

  // Bounded wait for a speed_valid pulse; n is the number of falling edges consumed
  task automatic wait_valid(input bit sat, input int limit, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && (n < limit)) begin
      @(negedge clk);
      n++;
      if (sat ? speed_valid_sat : speed_valid) seen = 1'b1;
    end
  endtask

  task automatic send_sample(input int d);
    range_valid = 1'b1;
    range_data  = 7'(d);
    @(negedge clk);
    range_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    bit seen;
    int exp;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (car_speed !== 8'd0) begin errors++; $display("FAIL rst_car_speed got %0d want 0", car_speed); end
    checks++; if (leading_distance !== 7'd0) begin errors++; $display("FAIL rst_distance got %0d want 0", leading_distance); end
    checks++; if (speed_valid !== 1'b0) begin errors++; $display("FAIL rst_speed_valid got %b want 0", speed_valid); end
    checks++; if (range_fault !== 1'b0) begin errors++; $display("FAIL rst_range_fault got %b want 0", range_fault); end
    rst = 1'b0;
    speed_q.push_back(0);
    wait_valid(1'b0, 40, n, seen);
    exp = speed_q.pop_front();
    checks++; if (!seen || n != int'(WIN)) begin errors++; $display("FAIL first_window_len got %0d (seen %b) want %0d", n, seen, WIN); end
    checks++; if (car_speed !== 8'(exp)) begin errors++; $display("FAIL first_window_speed got %0d want %0d", car_speed, exp); end
  endtask

  task automatic test_speed();
    int n;
    bit seen;
    int exp;
    wait_valid(1'b0, 40, n, seen);
    drive_pulses(7, 1'b0);
    speed_q.push_back(7);
    wait_valid(1'b0, 40, n, seen);
    exp = speed_q.pop_front();
    checks++; if (!seen || n != 6) begin errors++; $display("FAIL speed7_timing got %0d (seen %b) want 6", n, seen); end
    checks++; if (car_speed !== 8'(exp)) begin errors++; $display("FAIL speed7_value got %0d want %0d", car_speed, exp); end
    @(negedge clk);
    checks++; if (speed_valid !== 1'b0) begin errors++; $display("FAIL speed7_valid_width got %b want 0", speed_valid); end
    checks++; if (car_speed !== 8'd7) begin errors++; $display("FAIL speed7_hold got %0d want 7", car_speed); end
    speed_q.push_back(0);
    wait_valid(1'b0, 40, n, seen);
    exp = speed_q.pop_front();
    checks++; if (!seen || car_speed !== 8'(exp)) begin errors++; $display("FAIL speed_idle got %0d (seen %b) want %0d", car_speed, seen, exp); end
  endtask

  task automatic test_last_cycle_tick();
    int n;
    bit seen;
    int exp;
    wait_valid(1'b0, 40, n, seen);
    repeat (17) @(negedge clk);
    wheel_pulse = 1'b1;
    @(negedge clk);
    wheel_pulse = 1'b0;
    speed_q.push_back(1);
    wait_valid(1'b0, 40, n, seen);
    exp = speed_q.pop_front();
    checks++; if (!seen || n != 2) begin errors++; $display("FAIL last_tick_timing got %0d (seen %b) want 2", n, seen); end
    checks++; if (car_speed !== 8'(exp)) begin errors++; $display("FAIL last_tick_value got %0d want %0d", car_speed, exp); end
    speed_q.push_back(0);
    wait_valid(1'b0, 40, n, seen);
    exp = speed_q.pop_front();
    checks++; if (!seen || car_speed !== 8'(exp)) begin errors++; $display("FAIL last_tick_next got %0d (seen %b) want %0d", car_speed, seen, exp); end
  endtask

  task automatic test_saturation();
    int n;
    bit seen;
    int exp;
    wait_valid(1'b1, 800, n, seen);
    checks++; if (!seen) begin errors++; $display("FAIL sat_boundary got timeout want speed_valid"); end
    drive_pulses(300, 1'b1);
    speed_q.push_back(255);
    wait_valid(1'b1, 200, n, seen);
    exp = speed_q.pop_front();
    checks++; if (!seen || n != 100) begin errors++; $display("FAIL sat_timing got %0d (seen %b) want 100", n, seen); end
    checks++; if (car_speed_sat !== 8'(exp)) begin errors++; $display("FAIL sat_value got %0d want %0d", car_speed_sat, exp); end
  endtask

  task automatic test_average();
    int samp[5] = '{80, 80, 40, 40, 10};
    int want[5] = '{0, 0, 0, 60, 42};
    int exp;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      dist_q.push_back(want[i]);
      send_sample(samp[i]);
      exp = dist_q.pop_front();
      checks++; if (leading_distance !== 7'(exp)) begin errors++; $display("FAIL avg_s%0d got %0d want %0d", i, leading_distance, exp); end
    end
    checks++; if (range_fault !== 1'b0) begin errors++; $display("FAIL avg_fault got %b want 0", range_fault); end
  endtask

  task automatic test_coincidence();
    int exp;
    repeat (TMO - 1) @(negedge clk);
    checks++; if (range_fault !== 1'b0) begin errors++; $display("FAIL coin_pre_fault got %b want 0", range_fault); end
    dist_q.push_back(45);
    send_sample(90);
    exp = dist_q.pop_front();
    checks++; if (range_fault !== 1'b0) begin errors++; $display("FAIL coin_fault got %b want 0", range_fault); end
    checks++; if (leading_distance !== 7'(exp)) begin errors++; $display("FAIL coin_distance got %0d want %0d", leading_distance, exp); end
  endtask

  task automatic test_timeout();
    int exp;
    dist_q.push_back(57);
    send_sample(90);
    exp = dist_q.pop_front();
    checks++; if (leading_distance !== 7'(exp)) begin errors++; $display("FAIL to_start_distance got %0d want %0d", leading_distance, exp); end
    repeat (TMO - 1) @(negedge clk);
    checks++; if (range_fault !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", range_fault); end
    checks++; if (leading_distance !== 7'd57) begin errors++; $display("FAIL to_early_distance got %0d want 57", leading_distance); end
    @(negedge clk);
    checks++; if (range_fault !== 1'b1) begin errors++; $display("FAIL to_fault got %b want 1", range_fault); end
    checks++; if (leading_distance !== 7'd0) begin errors++; $display("FAIL to_distance got %0d want 0", leading_distance); end
    @(negedge clk);
    checks++; if (range_fault !== 1'b1) begin errors++; $display("FAIL to_hold got %b want 1", range_fault); end
  endtask

  task automatic test_recovery();
    int samp[4] = '{100, 20, 20, 20};
    int want[4] = '{0, 0, 0, 40};
    int exp;
    for (int i = 0; i < 4; i++) begin
      dist_q.push_back(want[i]);
      send_sample(samp[i]);
      exp = dist_q.pop_front();
      checks++; if (range_fault !== 1'b0) begin errors++; $display("FAIL rec_fault_s%0d got %b want 0", i, range_fault); end
      checks++; if (leading_distance !== 7'(exp)) begin errors++; $display("FAIL rec_distance_s%0d got %0d want %0d", i, leading_distance, exp); end
    end
  endtask

  task automatic test_reset_mid_window();
    int n;
    bit seen;
    int exp;
    wait_valid(1'b0, 40, n, seen);
    drive_pulses(4, 1'b0);
    speed_q.push_back(4);
    wait_valid(1'b0, 40, n, seen);
    exp = speed_q.pop_front();
    checks++; if (!seen || car_speed !== 8'(exp)) begin errors++; $display("FAIL pre_rst_speed got %0d (seen %b) want %0d", car_speed, seen, exp); end
    drive_pulses(5, 1'b0);
    for (int i = 0; i < 4; i++) send_sample(24);
    checks++; if (leading_distance !== 7'd24) begin errors++; $display("FAIL pre_rst_distance got %0d want 24", leading_distance); end
    #2 rst = 1'b1;
    #1;
    checks++; if (car_speed !== 8'd0) begin errors++; $display("FAIL mid_rst_speed got %0d want 0", car_speed); end
    checks++; if (leading_distance !== 7'd0) begin errors++; $display("FAIL mid_rst_distance got %0d want 0", leading_distance); end
    checks++; if (speed_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", speed_valid); end
    checks++; if (range_fault !== 1'b0) begin errors++; $display("FAIL mid_rst_fault got %b want 0", range_fault); end
    @(negedge clk);
    rst = 1'b0;
    drive_pulses(3, 1'b0);
    speed_q.push_back(3);
    wait_valid(1'b0, 40, n, seen);
    exp = speed_q.pop_front();
    checks++; if (!seen || n != int'(WIN) - 6) begin errors++; $display("FAIL post_rst_timing got %0d (seen %b) want %0d", n, seen, WIN - 6); end
    checks++; if (car_speed !== 8'(exp)) begin errors++; $display("FAIL post_rst_speed got %0d want %0d", car_speed, exp); end
  endtask

  initial begin
    rst             = 1'b1;
    wheel_pulse     = 1'b0;
    wheel_pulse_sat = 1'b0;
    range_valid     = 1'b0;
    range_data      = 7'd0;
    test_reset();
    test_speed();
    test_last_cycle_tick();
    test_saturation();
    test_average();
    test_coincidence();
    test_timeout();
    test_recovery();
    test_reset_mid_window();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
